// File: rtl/cla_pkg.sv
// Shared sizing helper for the hierarchical carry-lookahead adder and its benches.
package cla_pkg;

    // Operand width of a tree with the given group size and depth: n**levels.
    function automatic int unsigned cla_width(input int unsigned n, input int unsigned levels);
        int unsigned w;
        w = 1;
        for (int unsigned i = 0; i < levels; i++) begin
            w = w * n;
        end
        return w;
    endfunction

endpackage

// File: rtl/cla_unit.sv
// One lookahead unit: N (P,G) pairs plus a carry-in give per-position carries and group P/G.
module cla_unit #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] p,
    input  logic [N-1:0] g,
    input  logic         cin,
    output logic [N-1:0] c,
    output logic         gp,
    output logic         gg
);

    // c[j] is the carry into position j, each one an independent sum of products.
    always_comb begin
        logic term;
        c    = '0;
        term = 1'b0;
        for (int unsigned j = 0; j < N; j++) begin
            term = cin;
            for (int unsigned k = 0; k < j; k++) begin
                term = term & p[k];
            end
            c[j] = term;
            for (int unsigned i = 0; i < j; i++) begin
                term = g[i];
                for (int unsigned k = i + 1; k < j; k++) begin
                    term = term & p[k];
                end
                c[j] = c[j] | term;
            end
        end
    end

    // Group propagate/generate, kept separate so the up-tree path never waits on carries.
    always_comb begin
        logic term;
        gp   = &p;
        gg   = 1'b0;
        term = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            term = g[i];
            for (int unsigned k = i + 1; k < N; k++) begin
                term = term & p[k];
            end
            gg = gg | term;
        end
    end

endmodule

// File: rtl/carry_lookahead_adder.sv
// Registered W-bit adder (W = N**LEVELS) built from a tree of lookahead units.
module carry_lookahead_adder
    import cla_pkg::*;
#(
    parameter int unsigned N      = 4,
    parameter int unsigned LEVELS = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [cla_width(N, LEVELS)-1:0]  a,
    input  logic [cla_width(N, LEVELS)-1:0]  b,
    input  logic                             c_in,
    output logic [cla_width(N, LEVELS)-1:0]  sum,
    output logic                             c_out
);

    localparam int unsigned W = cla_width(N, LEVELS);

    if (N < 2 || LEVELS < 1) begin : g_bad_params
        $fatal(1, "carry_lookahead_adder: N must be >= 2 and LEVELS >= 1");
    end

    // Level k holds N**(LEVELS-k) nodes: lp/lg flow up the tree, lc flows back down.
    for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
        localparam int unsigned M = cla_width(N, LEVELS - k);

        logic [M-1:0] lp;
        logic [M-1:0] lg;
        logic [M-1:0] lc;

        if (k == 0) begin : g_leaf
            assign lp = a ^ b;
            assign lg = a & b;
        end else begin : g_units
            logic [M*N-1:0] uc;

            for (genvar u = 0; u < M; u++) begin : g_unit
                logic [N-1:0] up;
                logic [N-1:0] ug;

                assign up = g_lvl[k-1].lp[u*N +: N];
                assign ug = g_lvl[k-1].lg[u*N +: N];

                cla_unit #(
                    .N (N)
                ) u_cla (
                    .p   (up),
                    .g   (ug),
                    .cin (lc[u]),
                    .c   (uc[u*N +: N]),
                    .gp  (lp[u]),
                    .gg  (lg[u])
                );
            end
        end

        if (k == LEVELS) begin : g_root
            assign lc = c_in;
        end else begin : g_inner
            assign lc = g_lvl[k+1].g_units.uc;
        end
    end

    logic [W-1:0] sum_c;
    logic         c_out_c;

    assign sum_c   = g_lvl[0].lp ^ g_lvl[0].lc;
    assign c_out_c = g_lvl[LEVELS].lg[0] | (g_lvl[LEVELS].lp[0] & c_in);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum   <= '0;
            c_out <= 1'b0;
        end else begin
            sum   <= sum_c;
            c_out <= c_out_c;
        end
    end

endmodule

// File: tb/tb_carry_lookahead_adder.sv
// Directed and sweep checks for the registered carry-lookahead adder.
module tb_carry_lookahead_adder;
    import cla_pkg::*;

    localparam int unsigned W   = cla_width(4, 2);
    localparam int unsigned W23 = cla_width(2, 3);
    localparam int unsigned W24 = cla_width(2, 4);
    localparam int unsigned W32 = cla_width(3, 2);
    localparam int unsigned W41 = cla_width(4, 1);

    logic           clk;
    logic           rst;
    logic           tc;
    logic [15:0]    ta;
    logic [15:0]    tb;

    logic [W-1:0]   sum;
    logic           c_out;
    logic [W23-1:0] s23;
    logic           c23;
    logic [W24-1:0] s24;
    logic           c24;
    logic [W32-1:0] s32;
    logic           c32;
    logic [W41-1:0] s41;
    logic           c41;

    int n_cmp = 0;
    int n_err = 0;

    carry_lookahead_adder #(.N(4), .LEVELS(2)) dut (
        .clk(clk), .rst(rst), .a(ta[W-1:0]), .b(tb[W-1:0]), .c_in(tc), .sum(sum), .c_out(c_out)
    );
    carry_lookahead_adder #(.N(2), .LEVELS(3)) u23 (
        .clk(clk), .rst(rst), .a(ta[W23-1:0]), .b(tb[W23-1:0]), .c_in(tc), .sum(s23), .c_out(c23)
    );
    carry_lookahead_adder #(.N(2), .LEVELS(4)) u24 (
        .clk(clk), .rst(rst), .a(ta[W24-1:0]), .b(tb[W24-1:0]), .c_in(tc), .sum(s24), .c_out(c24)
    );
    carry_lookahead_adder #(.N(3), .LEVELS(2)) u32 (
        .clk(clk), .rst(rst), .a(ta[W32-1:0]), .b(tb[W32-1:0]), .c_in(tc), .sum(s32), .c_out(c32)
    );
    carry_lookahead_adder #(.N(4), .LEVELS(1)) u41 (
        .clk(clk), .rst(rst), .a(ta[W41-1:0]), .b(tb[W41-1:0]), .c_in(tc), .sum(s41), .c_out(c41)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: w-bit operands added in 32 bits, so the carry lands in bit w.
    function automatic logic [31:0] model(input int unsigned w, input logic [15:0] x,
                                          input logic [15:0] y, input logic ci);
        logic [31:0] m;
        m = (32'd1 << w) - 32'd1;
        return (32'(x) & m) + (32'(y) & m) + 32'(ci);
    endfunction

    task automatic apply(input logic [15:0] x, input logic [15:0] y, input logic ci);
        @(negedge clk);
        ta = x;
        tb = y;
        tc = ci;
        @(posedge clk);
        #1;
    endtask

    task automatic vec(input string tag, input logic [15:0] x, input logic [15:0] y,
                       input logic ci, input logic [31:0] exp);
        apply(x, y, ci);
        check(tag, 32'({c_out, sum}), exp);
    endtask

    task automatic check_all(input string tag);
        check({tag, "_4x2"}, 32'({c_out, sum}), model(W, ta, tb, tc));
        check({tag, "_2x3"}, 32'({c23, s23}), model(W23, ta, tb, tc));
        check({tag, "_2x4"}, 32'({c24, s24}), model(W24, ta, tb, tc));
        check({tag, "_3x2"}, 32'({c32, s32}), model(W32, ta, tb, tc));
        check({tag, "_4x1"}, 32'({c41, s41}), model(W41, ta, tb, tc));
    endtask

    initial begin
        rst = 1'b1;
        ta  = 16'hA5A5;
        tb  = 16'h1234;
        tc  = 1'b1;
        #2;
        check("rst_async", 32'({c_out, sum}), 32'd0);
        check("rst_async_3x2", 32'({c32, s32}), 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold", 32'({c_out, sum}), 32'd0);

        @(negedge clk);
        rst = 1'b0;
        ta  = 16'd0;
        tb  = 16'd0;
        tc  = 1'b0;
        @(posedge clk);
        #1;
        check("zero", 32'({c_out, sum}), 32'd0);

        vec("cin_only",     16'd0,     16'd0,     1'b1, 32'd1);
        vec("grp_63_1",     16'd63,    16'd1,     1'b0, 32'd64);
        vec("grp_95_c",     16'd95,    16'd0,     1'b1, 32'd96);
        vec("grp_3_12_c",   16'd3,     16'd12,    1'b1, 32'd16);
        vec("grp_255_1",    16'd255,   16'd1,     1'b0, 32'd256);
        vec("grp_255_255c", 16'd255,   16'd255,   1'b1, 32'd511);
        vec("full_ones_1",  16'hFFFF,  16'd1,     1'b0, 32'h10000);
        vec("full_ones_x2", 16'hFFFF,  16'hFFFF,  1'b1, 32'h1FFFF);
        vec("full_cin_prop",16'd0,     16'hFFFF,  1'b1, 32'h10000);
        vec("mixed",        16'd12345, 16'd54321, 1'b0, 32'd66666);

        // Reset landing between two vectors drops the in-flight result.
        vec("pre_rst", 16'd100, 16'd200, 1'b0, 32'd300);
        @(negedge clk);
        ta = 16'd1000;
        tb = 16'd2000;
        tc = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_mid_async", 32'({c_out, sum}), 32'd0);
        @(posedge clk);
        #1;
        check("rst_mid_edge", 32'({c_out, sum}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ta  = 16'd7;
        tb  = 16'd9;
        tc  = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst", 32'({c_out, sum}), 32'd17);

        for (int i = 0; i < 1000; i++) begin
            apply(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
            check_all("rand");
        end

        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            apply({12'd0, v[3:0]}, {12'd0, v[7:4]}, v[8]);
            check("exh_4x1", 32'({c41, s41}), model(W41, ta, tb, tc));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
